ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the execute block (ALU plus data memory).
- Registers the execute results and realigns load data, which the data memory returns one cycle late.
- Keeps the architectural Z/N flags and resolves J, JM, BRZ and BRN.
- Produces the register-file write port and the fetch-redirect signals.

Parameters:
DATA_W, 32, data/result width
REG_AW, 6, register address width (64 registers)
PC_W, 32, program counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  instruction from execute is valid this cycle
in_opcode  in  4  NOP 0000, SVPC 1111, LD 1110, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011
in_rd  in  REG_AW  destination register
in_result  in  DATA_W  ALU result
in_zero  in  1  ALU zero
in_neg  in  1  ALU negative
in_read_data  in  DATA_W  data memory output (valid the cycle after the load is captured)
in_target  in  PC_W  rs value used as jump/branch target
stall  out  1  hold upstream stages (load/JM wait)
wb_en  out  1  register write strobe
wb_addr  out  REG_AW  register write address
wb_data  out  DATA_W  register write data
flag_z  out  1  architectural zero flag
flag_n  out  1  architectural negative flag
redirect  out  1  one-cycle fetch redirect
redirect_pc  out  PC_W  redirect target

Behaviour:
- Reset, asynchronous: all outputs 0; state IDLE; the capture register is cleared.
- The capture register (opcode, rd, result, zero, neg, target) loads on a rising edge when in_valid=1 and state is not WAIT.
- When stall=1, upstream holds in_* constant. The stage ignores in_valid during WAIT.
- State IDLE/RUN:
  - ALU ops (ADD, INC, NEG, SUB, SVPC): wb_en=1 the cycle after capture, with wb_addr=rd and wb_data=result.
  - ADD, INC, NEG and SUB also update flag_z/flag_n from the captured zero/neg on that same edge. SVPC does not update flags.
  - LD and JM: go to WAIT; stall=1 combinationally in the cycle after capture.
  - ST, NOP: no write, no flag change.
  - J: redirect=1 for one cycle with redirect_pc=target.
  - BRZ: redirect=1 iff flag_z=1. BRN: redirect=1 iff flag_n=1.
  - Branches use the flags as they stand before this instruction. A branch immediately after an ALU op sees that op's flags, because the flags update on the same edge the ALU op is captured.
- State WAIT (exactly 1 cycle): sample in_read_data.
  - LD: wb_en=1, wb_data=in_read_data.
  - JM: redirect=1, redirect_pc=in_read_data[PC_W-1:0].
  - Then return to RUN (or IDLE if in_valid=0).
- Latency:
  - ALU/branch: result visible 1 cycle after capture.
  - LD/JM: 2 cycles.
  - Throughput is 1 per cycle except one bubble per LD/JM.
- wb_en and redirect are single-cycle pulses, registered outputs. wb_addr/wb_data/redirect_pc hold their last value when the strobe is low.
- in_valid=0: no capture, strobes deasserted, flags held.
- Reset mid-WAIT: the pending load/JM is dropped, with no wb_en and no redirect after reset release.
- Unknown opcodes are treated as NOP.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds three outputs:
  - fwd_valid out 1
  - fwd_addr out REG_AW
  - fwd_data out DATA_W
- These are a combinational copy of the pending write (the captured ALU result before the wb_en edge), so execute can bypass it. fwd_valid=0 in WAIT and after reset.
- When undefined, the ports are absent and behaviour is otherwise identical.

Test Plan:
- ADD rd=5, result=7, zero=0, neg=0 -> next cycle wb_en=1, wb_addr=5, wb_data=7; flag_z=0, flag_n=0.
- SUB result=0, zero=1, then BRZ target=0x40 back-to-back -> redirect=1, redirect_pc=0x40 for exactly 1 cycle.
- LD rd=3 with in_read_data=0xFFFFFFFC in the following cycle -> stall=1 for 1 cycle, then wb_en=1, wb_addr=3, wb_data=0xFFFFFFFC.
- NEG result=-4 (neg=1), then ST, then BRN target=0x10 -> ST leaves flags, flag_n=1, redirect to 0x10; a BRZ here does not redirect.
- JM with in_read_data=0x20 -> stall 1 cycle, then redirect=1, redirect_pc=0x20, wb_en=0.
- Assert reset during WAIT of an LD -> all outputs 0 immediately; no wb_en after release; flags 0.

Source files
------------

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: registers ALU results, realigns late load data, owns Z/N flags, resolves jumps/branches.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data bypass outputs.
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6,
  parameter int PC_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_neg,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [PC_W-1:0]   in_target,
  output logic              stall,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam logic [3:0] OP_SVPC = 4'b1111;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t            state, state_nx;
  logic              capture;
  logic              is_alu;
  logic [3:0]        cap_op;
  logic [REG_AW-1:0] cap_rd;

  logic              wb_en_nx, redirect_nx, flag_z_nx, flag_n_nx;
  logic [REG_AW-1:0] wb_addr_nx;
  logic [DATA_W-1:0] wb_data_nx;
  logic [PC_W-1:0]   redirect_pc_nx;

  assign capture = in_valid && (state != WAIT);
  assign is_alu  = (in_opcode == OP_ADD) || (in_opcode == OP_INC) || (in_opcode == OP_NEG) ||
                   (in_opcode == OP_SUB) || (in_opcode == OP_SVPC);
  assign stall   = (state == WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cap_op <= '0;
      cap_rd <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        cap_op <= in_opcode;
        cap_rd <= in_rd;
      end
    end
  end

  // Flags and branch decisions resolve at capture, so the WAIT state only needs opcode and rd.
  always_comb begin
    state_nx       = state;
    wb_en_nx       = 1'b0;
    wb_addr_nx     = wb_addr;
    wb_data_nx     = wb_data;
    redirect_nx    = 1'b0;
    redirect_pc_nx = redirect_pc;
    flag_z_nx      = flag_z;
    flag_n_nx      = flag_n;
    if (state == WAIT) begin
      state_nx = in_valid ? RUN : IDLE;
      if (cap_op == OP_LD) begin
        wb_en_nx   = 1'b1;
        wb_addr_nx = cap_rd;
        wb_data_nx = in_read_data;
      end else begin
        redirect_nx    = 1'b1;
        redirect_pc_nx = in_read_data[PC_W-1:0];
      end
    end else if (in_valid) begin
      state_nx = RUN;
      if (is_alu) begin
        wb_en_nx   = 1'b1;
        wb_addr_nx = in_rd;
        wb_data_nx = in_result;
        if (in_opcode != OP_SVPC) begin
          flag_z_nx = in_zero;
          flag_n_nx = in_neg;
        end
      end
      case (in_opcode)
        OP_LD, OP_JM: state_nx = WAIT;
        OP_J: begin
          redirect_nx    = 1'b1;
          redirect_pc_nx = in_target;
        end
        OP_BRZ: if (flag_z) begin
          redirect_nx    = 1'b1;
          redirect_pc_nx = in_target;
        end
        OP_BRN: if (flag_n) begin
          redirect_nx    = 1'b1;
          redirect_pc_nx = in_target;
        end
        default: ;
      endcase
    end else begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
    end else begin
      wb_en       <= wb_en_nx;
      wb_addr     <= wb_addr_nx;
      wb_data     <= wb_data_nx;
      redirect    <= redirect_nx;
      redirect_pc <= redirect_pc_nx;
      flag_z      <= flag_z_nx;
      flag_n      <= flag_n_nx;
    end
  end

`ifdef WB_FWD_EN
  logic              cap_alu;
  logic [DATA_W-1:0] cap_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_alu    <= 1'b0;
      cap_result <= '0;
    end else begin
      cap_alu <= capture && is_alu;
      if (capture) cap_result <= in_result;
    end
  end

  assign fwd_valid = cap_alu && (state != WAIT);
  assign fwd_addr  = cap_rd;
  assign fwd_data  = cap_result;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: directed scenarios followed by random instruction streams
// checked against a per-instruction reference model.
module tb_ex_wb_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 6;
  localparam int PC_W   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [3:0]        in_opcode;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_neg;
  logic [DATA_W-1:0] in_read_data;
  logic [PC_W-1:0]   in_target;
  logic              stall, wb_en, flag_z, flag_n, redirect;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [PC_W-1:0]   redirect_pc;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  ex_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_result(in_result), .in_zero(in_zero), .in_neg(in_neg), .in_read_data(in_read_data),
    .in_target(in_target), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_z(flag_z), .flag_n(flag_n), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // architectural view held by the model
  logic              m_z, m_n;
  logic [REG_AW-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic [PC_W-1:0]   h_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic e_wb, input logic e_red, input logic e_stall);
    check("wb_en", 32'(wb_en), 32'(e_wb));
    check("wb_addr", 32'(wb_addr), 32'(h_addr));
    check("wb_data", wb_data, h_data);
    check("redirect", 32'(redirect), 32'(e_red));
    check("redirect_pc", redirect_pc, h_pc);
    check("flag_z", 32'(flag_z), 32'(m_z));
    check("flag_n", 32'(flag_n), 32'(m_n));
    check("stall", 32'(stall), 32'(e_stall));
  endtask

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111};
  endfunction

  task automatic model_reset();
    m_z = 0; m_n = 0; h_addr = '0; h_data = '0; h_pc = '0;
  endtask

  // One instruction: held until the stage consumes it, then outputs compared with the model.
  task automatic issue(input logic [3:0] op, input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] res,
                       input logic z, input logic n, input logic [PC_W-1:0] tgt,
                       input logic [DATA_W-1:0] rdata);
    logic e_wb, e_red;
    e_wb = 0; e_red = 0;
    @(negedge clock);
    in_valid = 1; in_opcode = op; in_rd = rd; in_result = res; in_zero = z; in_neg = n;
    in_target = tgt; in_read_data = $urandom;
    if (op == 4'b1000 || (op == 4'b1001 && m_z) || (op == 4'b1011 && m_n)) begin
      e_red = 1; h_pc = tgt;
    end
    if (is_alu_op(op)) begin
      e_wb = 1; h_addr = rd; h_data = res;
      if (op != 4'b1111) begin m_z = z; m_n = n; end
    end
    @(posedge clock); #1;
    if (op == 4'b1110 || op == 4'b1010) begin
      check_all(0, 0, 1);
      @(negedge clock);
      in_read_data = rdata;
      @(posedge clock); #1;
      if (op == 4'b1110) begin
        h_addr = rd; h_data = rdata;
        check_all(1, 0, 0);
      end else begin
        h_pc = rdata[PC_W-1:0];
        check_all(0, 1, 0);
      end
    end else begin
      check_all(e_wb, e_red, 0);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 0; in_opcode = 4'($urandom); in_rd = REG_AW'($urandom); in_result = $urandom;
    in_zero = 1'($urandom); in_neg = 1'($urandom); in_target = $urandom; in_read_data = $urandom;
    @(posedge clock); #1;
    check_all(0, 0, 0);
  endtask

  initial begin
    logic [3:0]        op;
    logic [DATA_W-1:0] res;
    reset = 1; in_valid = 0; in_opcode = '0; in_rd = '0; in_result = '0; in_zero = 0; in_neg = 0;
    in_read_data = '0; in_target = '0;
    model_reset();
    #2;
    check_all(0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;

    issue(4'b0100, 6'd5, 32'd7, 0, 0, 32'h0, 32'h0);
    check("add_wb_data", wb_data, 32'd7);
    issue(4'b0111, 6'd1, 32'd0, 1, 0, 32'h0, 32'h0);
    issue(4'b1001, 6'd0, 32'd0, 0, 0, 32'h40, 32'h0);
    check("brz_pc", redirect_pc, 32'h40);
    idle();
    issue(4'b1110, 6'd3, 32'd0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    check("ld_data", wb_data, 32'hFFFF_FFFC);
    issue(4'b0110, 6'd9, 32'hFFFF_FFFC, 0, 1, 32'h0, 32'h0);
    issue(4'b0011, 6'd2, 32'h1234, 1, 0, 32'h0, 32'h0);
    issue(4'b1011, 6'd0, 32'h0, 0, 0, 32'h10, 32'h0);
    check("brn_pc", redirect_pc, 32'h10);
    issue(4'b1001, 6'd0, 32'h0, 0, 0, 32'h99, 32'h0);
    issue(4'b1010, 6'd0, 32'h0, 0, 0, 32'h0, 32'h20);
    check("jm_pc", redirect_pc, 32'h20);
    issue(4'b1000, 6'd0, 32'h0, 0, 0, 32'hABC0, 32'h0);
    issue(4'b1111, 6'd7, 32'h5000, 1, 1, 32'h0, 32'h0);

    // reset while a load waits for its data
    @(negedge clock);
    in_valid = 1; in_opcode = 4'b1110; in_rd = 6'd3; in_read_data = $urandom;
    @(posedge clock); #1;
    check("rst_ld_stall", 32'(stall), 32'd1);
    #1 reset = 1;
    #1;
    model_reset();
    check_all(0, 0, 0);
    @(negedge clock);
    in_valid = 0; in_read_data = 32'hFFFF_FFFC;
    @(negedge clock);
    reset = 0;
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        op  = 4'($urandom_range(0, 15));
        res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        issue(op, REG_AW'($urandom), res, (res == 0), res[31], $urandom, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
